// File: rtl/serial_adder_seq.sv
// Bit-serial adder/subtractor: DIGIT bits per clock, LSB digit first.
// Operands in and results out on valid/ready handshakes.
module serial_adder_seq #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;

  logic [CW-1:0] count;
  logic carry;
  // a_sh holds A; sum digits fill in from the top as A drains out
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;

  logic [DIGIT-1:0] ad;
  logic [DIGIT-1:0] bd;
  logic [DIGIT:0] dsum;
  logic [WIDTH-1:0] a_next;
  logic msb_cin;

  // one DIGIT-wide add step and the shifted operand/sum register
  always_comb begin
    ad = a_sh[DIGIT-1:0];
    bd = b_sh[DIGIT-1:0];
    dsum = {1'b0, ad} + {1'b0, bd} + {{DIGIT{1'b0}}, carry};
    a_next = WIDTH'({dsum[DIGIT-1:0], a_sh} >> DIGIT);
    msb_cin = ad[DIGIT-1] ^ bd[DIGIT-1] ^ dsum[DIGIT-1];
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);

  // control FSM, datapath shift registers and registered results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      carry    <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      Sum      <= '0;
      Cout     <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= A;
            b_sh  <= Sub ? ~B : B;
            carry <= Sub ? ~Cin : Cin;
            count <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_next;
          b_sh  <= b_sh >> DIGIT;
          carry <= dsum[DIGIT];
          count <= count + CW'(1);
          if (count == LAST) begin
            Sum      <= a_next;
            Cout     <= dsum[DIGIT];
            Overflow <= msb_cin ^ dsum[DIGIT];
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed and lightly randomised checks of serial_adder_seq
// on an 8-bit/1-bit-digit and an 8-bit/4-bit-digit instance.
module tb_serial_adder_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       iv[2];
  logic       ordy[2];
  logic [7:0] a[2];
  logic [7:0] b[2];
  logic       ci[2];
  logic       su[2];
  logic       ir[2];
  logic [7:0] sm[2];
  logic       co[2];
  logic       ovf[2];
  logic       ov[2];
  logic       bz[2];

  int checks = 0;
  int errors = 0;

  serial_adder_seq #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .A(a[0]), .B(b[0]), .Cin(ci[0]), .Sub(su[0]),
    .Sum(sm[0]), .Cout(co[0]), .Overflow(ovf[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .busy(bz[0])
  );

  serial_adder_seq #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .A(a[1]), .B(b[1]), .Cin(ci[1]), .Sub(su[1]),
    .Sum(sm[1]), .Cout(co[1]), .Overflow(ovf[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .busy(bz[1])
  );

  // start an operation, wait for out_valid (bounded), optionally stall, consume
  task automatic run_op(input int d, input logic [7:0] x, input logic [7:0] y,
                        input logic c, input logic s, input int pre,
                        input int post, output int lat, output logic vld);
    repeat (pre) @(negedge clk);
    @(negedge clk);
    a[d] = x; b[d] = y; ci[d] = c; su[d] = s; iv[d] = 1'b1;
    @(posedge clk); #1;
    iv[d] = 1'b0;
    lat = 0;
    while (!ov[d] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    vld = ov[d];
    repeat (post) @(negedge clk);
    @(negedge clk);
    ordy[d] = 1'b1;
    @(posedge clk); #1;
    ordy[d] = 1'b0;
  endtask

  task automatic test_reset;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({sm[d], co[d], ovf[d], ov[d], bz[d], ir[d]} !== {8'h00, 5'b00001}) begin
        errors++;
        $display("FAIL reset d%0d: sum=%h co=%b ovf=%b ov=%b busy=%b ir=%b want 00 0 0 0 0 1",
                 d, sm[d], co[d], ovf[d], ov[d], bz[d], ir[d]);
      end
    end
  endtask

  task automatic test_add_overflow;
    int lat; logic vld;
    run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 0, 0, lat, vld);
    checks++;
    if ({vld, sm[0], co[0], ovf[0]} !== {1'b1, 8'h80, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL add_ovf: v=%b sum=%h co=%b ovf=%b want 1 80 0 1", vld, sm[0], co[0], ovf[0]);
    end
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL add_ovf latency: got %0d want 8", lat);
    end
    checks++;
    if (ir[0] !== 1'b1) begin
      errors++;
      $display("FAIL add_ovf in_ready after consume: got %b want 1", ir[0]);
    end
  endtask

  task automatic test_sub;
    int lat; logic vld;
    run_op(0, 8'h05, 8'h07, 1'b0, 1'b1, 0, 0, lat, vld);
    checks++;
    if ({vld, sm[0], co[0], ovf[0]} !== {1'b1, 8'hFE, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sub_borrow: v=%b sum=%h co=%b ovf=%b want 1 fe 0 0", vld, sm[0], co[0], ovf[0]);
    end
    run_op(0, 8'h80, 8'h01, 1'b0, 1'b1, 1, 2, lat, vld);
    checks++;
    if ({vld, sm[0], co[0], ovf[0]} !== {1'b1, 8'h7F, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL sub_ovf: v=%b sum=%h co=%b ovf=%b want 1 7f 1 1", vld, sm[0], co[0], ovf[0]);
    end
    run_op(0, 8'h10, 8'h03, 1'b1, 1'b1, 0, 0, lat, vld);
    checks++;
    if ({sm[0], co[0], ovf[0]} !== {8'h0C, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sub_bin: sum=%h co=%b ovf=%b want 0c 1 0", sm[0], co[0], ovf[0]);
    end
  endtask

  task automatic test_digit4;
    int lat; logic vld;
    run_op(1, 8'hFF, 8'h01, 1'b1, 1'b0, 0, 0, lat, vld);
    checks++;
    if ({vld, sm[1], co[1], ovf[1]} !== {1'b1, 8'h01, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL digit4: v=%b sum=%h co=%b ovf=%b want 1 01 1 0", vld, sm[1], co[1], ovf[1]);
    end
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL digit4 latency: got %0d want 2", lat);
    end
    run_op(1, 8'h80, 8'h01, 1'b0, 1'b1, 0, 0, lat, vld);
    checks++;
    if ({sm[1], co[1], ovf[1]} !== {8'h7F, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL digit4 sub: sum=%h co=%b ovf=%b want 7f 1 1", sm[1], co[1], ovf[1]);
    end
  endtask

  task automatic test_backpressure;
    int lat;
    int bad;
    @(negedge clk);
    a[0] = 8'h33; b[0] = 8'h44; ci[0] = 1'b0; su[0] = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    lat = 0;
    while (!ov[0] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if ({ov[0], sm[0]} !== {1'b1, 8'h77}) begin
      errors++;
      $display("FAIL bp result: v=%b sum=%h want 1 77", ov[0], sm[0]);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      iv[0] = i[0];
      a[0] = 8'(i * 17); b[0] = 8'(i * 5 + 1); su[0] = i[1];
      @(posedge clk); #1;
      if ({ov[0], ir[0], bz[0], sm[0], co[0], ovf[0]} !== {3'b100, 8'h77, 2'b00}) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bp hold: %0d bad cycles, last v=%b ir=%b sum=%h want 0", bad, ov[0], ir[0], sm[0]);
    end
    @(negedge clk);
    iv[0] = 1'b1; a[0] = 8'h01; b[0] = 8'h02; ci[0] = 1'b0; su[0] = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    checks++;
    if ({ir[0], bz[0], ov[0]} !== 3'b100) begin
      errors++;
      $display("FAIL bp release: ir=%b busy=%b v=%b want 1 0 0", ir[0], bz[0], ov[0]);
    end
    @(posedge clk); #1;
    iv[0] = 1'b0;
    checks++;
    if ({ir[0], bz[0]} !== 2'b01) begin
      errors++;
      $display("FAIL bp accept: ir=%b busy=%b want 0 1", ir[0], bz[0]);
    end
    lat = 0;
    while (!ov[0] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if ({sm[0], lat} !== {8'h03, 32'd8}) begin
      errors++;
      $display("FAIL bp next op: sum=%h lat=%0d want 03 8", sm[0], lat);
    end
    @(negedge clk);
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    int lat; logic vld;
    @(negedge clk);
    a[0] = 8'h5A; b[0] = 8'h21; ci[0] = 1'b1; su[0] = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({sm[0], co[0], ovf[0], ov[0], bz[0], ir[0]} !== {8'h00, 5'b00001}) begin
      errors++;
      $display("FAIL mid_run reset: sum=%h co=%b ovf=%b v=%b busy=%b ir=%b want 00 0 0 0 0 1",
               sm[0], co[0], ovf[0], ov[0], bz[0], ir[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(0, 8'h10, 8'h20, 1'b0, 1'b0, 0, 0, lat, vld);
    checks++;
    if ({vld, sm[0], co[0], ovf[0], lat} !== {1'b1, 8'h30, 2'b00, 32'd8}) begin
      errors++;
      $display("FAIL after reset: v=%b sum=%h co=%b ovf=%b lat=%0d want 1 30 0 0 8",
               vld, sm[0], co[0], ovf[0], lat);
    end
  endtask

  task automatic test_random;
    int lat; logic vld;
    logic [7:0] x, y, bb, rs;
    logic c, s, rc, ro;
    logic [8:0] full;
    int bad [2];
    bad[0] = 0; bad[1] = 0;
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 150; n++) begin
        x = 8'($urandom); y = 8'($urandom);
        c = 1'($urandom); s = 1'($urandom);
        bb = s ? ~y : y;
        full = {1'b0, x} + {1'b0, bb} + {8'h00, (s ? ~c : c)};
        rs = full[7:0]; rc = full[8];
        ro = (x[7] == bb[7]) && (rs[7] != x[7]);
        run_op(d, x, y, c, s, int'($urandom_range(0, 2)),
               int'($urandom_range(0, 3)), lat, vld);
        if ({vld, sm[d], co[d], ovf[d], lat} !== {1'b1, rs, rc, ro, (d == 0) ? 32'd8 : 32'd2}) begin
          if (bad[d] < 4)
            $display("FAIL rand d%0d: %h %s %h c%b -> sum=%h co=%b ovf=%b lat=%0d want %h %b %b",
                     d, x, s ? "-" : "+", y, c, sm[d], co[d], ovf[d], lat, rs, rc, ro);
          bad[d]++;
        end
      end
      checks++;
      if (bad[d] !== 0) begin
        errors++;
        $display("FAIL rand d%0d summary: %0d bad ops want 0", d, bad[d]);
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b0;
      a[d] = '0; b[d] = '0; ci[d] = 1'b0; su[d] = 1'b0;
    end
    #12;
    test_reset;
    @(negedge clk);
    rst = 1'b0;
    test_add_overflow;
    test_sub;
    test_digit4;
    test_backpressure;
    test_reset_mid_run;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
